sync_updown_counter: RTL

Parametrised synchronous counter, the next generation of the team's fixed 4-bit down counter. It adds configurable width and modulus, up, down, ping-pong and hold modes, and synchronous load. It also provides wrap-or-saturate behaviour, terminal-count and wrap flags, and a direction output. It is used as a generic timebase and sequencing counter by control logic in the same clock domain.

---
 rtl/sync_counter_pkg.sv | 18 +
 rtl/sync_counter_next.sv | 94 +++++++++
 rtl/sync_updown_counter.sv | 72 +++++++
 3 files changed

// File: rtl/sync_counter_pkg.sv
// rtl/sync_counter_pkg.sv - shared encodings for the parametrised up/down counter
package sync_counter_pkg;

    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // The ping-pong FSM state is the dir register itself.
    typedef enum logic {
        UP_S   = 1'b0,
        DOWN_S = 1'b1
    } pp_state_t;

endpackage

// File: rtl/sync_counter_next.sv
// rtl/sync_counter_next.sv - next-state, wrap and terminal-count decode for the counter
module sync_counter_next
    import sync_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = 0
) (
    input  logic [WIDTH-1:0] counter,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             en,
    output logic [WIDTH-1:0] count_next,
    output logic             dir_next,
    output logic             wrap_next,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    pp_state_t pp_state;
    logic      at_top;
    logic      at_bot;

    assign pp_state = pp_state_t'(dir);
    assign at_top   = (counter == MAXV);
    assign at_bot   = (counter == ZERO);

    always_comb begin
        count_next = counter;
        dir_next   = dir;
        wrap_next  = 1'b0;
        case (mode)
            MODE_UP: begin
                dir_next = DIR_UP;
                if (en) begin
                    if (!at_top) begin
                        count_next = counter + ONE;
                    end else if (SATURATE == 0) begin
                        count_next = ZERO;
                        wrap_next  = 1'b1;
                    end
                end
            end
            MODE_DOWN: begin
                dir_next = DIR_DOWN;
                if (en) begin
                    if (!at_bot) begin
                        count_next = counter - ONE;
                    end else if (SATURATE == 0) begin
                        count_next = MAXV;
                        wrap_next  = 1'b1;
                    end
                end
            end
            MODE_PINGPONG: begin
                if (en) begin
                    case (pp_state)
                        UP_S: begin
                            if (!at_top) begin
                                count_next = counter + ONE;
                            end else begin
                                count_next = MAXV - ONE;
                                dir_next   = DIR_DOWN;
                                wrap_next  = 1'b1;
                            end
                        end
                        DOWN_S: begin
                            if (!at_bot) begin
                                count_next = counter - ONE;
                            end else begin
                                count_next = ONE;
                                dir_next   = DIR_UP;
                                wrap_next  = 1'b1;
                            end
                        end
                        default: begin
                            count_next = counter;
                        end
                    endcase
                end
            end
            default: begin
                count_next = counter;
            end
        endcase
    end

    // tc uses the registered dir so a cascaded stage sees it before the wrapping edge.
    assign tc = en && (mode != MODE_HOLD) && ((dir == DIR_UP) ? at_top : at_bot);

endmodule

// File: rtl/sync_updown_counter.sv
// rtl/sync_updown_counter.sv - parametrised up/down/ping-pong counter with load and flags
module sync_updown_counter
    import sync_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             dir,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_next;
    logic             dir_next;
    logic             wrap_next;
    logic [WIDTH-1:0] load_clamped;
    logic             load_dir;

    sync_counter_next #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .SATURATE  (SATURATE)
    ) u_next (
        .counter    (counter),
        .dir        (dir),
        .mode       (mode),
        .en         (en),
        .count_next (count_next),
        .dir_next   (dir_next),
        .wrap_next  (wrap_next),
        .tc         (tc)
    );

    assign load_clamped = (load_val > MAXV) ? MAXV : load_val;

    // A load never takes a ping-pong turn, so dir only follows the forcing modes.
    always_comb begin
        load_dir = dir;
        if (mode == MODE_UP) begin
            load_dir = DIR_UP;
        end else if (mode == MODE_DOWN) begin
            load_dir = DIR_DOWN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            dir     <= DIR_UP;
            wrap    <= 1'b0;
        end else if (load) begin
            counter <= load_clamped;
            dir     <= load_dir;
            wrap    <= 1'b0;
        end else begin
            counter <= count_next;
            dir     <= dir_next;
            wrap    <= wrap_next;
        end
    end

endmodule
